// File: rtl/frogg_pkg.sv
// Shared Frogger game-flow definitions: state encodings, field widths and
// score saturation. Also imported by the top-level colour/overlay logic.
package frogg_pkg;

    localparam int SCORE_W   = 10;
    localparam int LEVEL_W   = 4;
    localparam int LIVES_W   = 2;
    localparam int TIME_W    = 7;
    localparam int SPEED_W   = 4;
    localparam int FRAME_W   = 16;

    localparam int SCORE_MAX = 999;
    localparam int LEVEL_MAX = 15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READY     = 3'd1,
        RUNNING   = 3'd2,
        DYING     = 3'd3,
        LEVEL_UP  = 3'd4,
        GAME_OVER = 3'd5
    } game_state_t;

    // Add points using one extra bit of headroom, then clamp to the display limit
    function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] score,
                                                     input logic [SCORE_W:0]   points);
        logic [SCORE_W:0] sum;
        sum = {1'b0, score} + points;
        if (sum > (SCORE_W+1)'(SCORE_MAX))
            return SCORE_W'(SCORE_MAX);
        return sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/frogg_frame_timer.sv
// Frame-tick counter with a programmable terminal count. 'done' is a
// one-cycle combinational strobe on the tick that reaches the terminal
// count; the counter then wraps to zero. 'clear' restarts the count.
module frogg_frame_timer #(
    parameter int W = 16
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         tick,
    input  logic [W-1:0] terminal,
    output logic         done
);

    logic [W-1:0] count;

    assign done = enable && tick && (count == terminal - W'(1));

    // Count enabled ticks, wrapping on done; clear and reset take priority
    always_ff @(posedge i_Clk) begin
        if (i_Rst || clear)
            count <= '0;
        else if (enable && tick)
            count <= done ? '0 : count + W'(1);
    end

endmodule

// File: rtl/frogg_round_ctrl.sv
// Frogger game-flow sequencer: owns lives, level, score, car speed and the
// per-crossing countdown, and gates game activity / frog respawn.
// Optional build macro FROGG_TIME_BONUS_EN: a successful crossing also adds
// the seconds remaining to the score.
module frogg_round_ctrl
    import frogg_pkg::*;
#(
    parameter int P_LIVES          = 3,
    parameter int P_FRAMES_PER_SEC = 60,
    parameter int P_TIME_LIMIT     = 30,
    parameter int P_READY_FRAMES   = 90,
    parameter int P_DEATH_FRAMES   = 60,
    parameter int P_LEVELUP_FRAMES = 60,
    parameter int P_CROSS_POINTS   = 10,
    parameter int P_MAX_SPEED      = 15
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Frame_Tick,
    input  logic               i_Start_Btn,
    input  logic               i_Collision,
    input  logic               i_Reached_Top,
    output logic               o_Game_Active,
    output logic               o_Frog_Reset,
    output logic [SPEED_W-1:0] o_Car_Speed,
    output logic [LIVES_W-1:0] o_Lives,
    output logic [LEVEL_W-1:0] o_Level,
    output logic [SCORE_W-1:0] o_Score,
    output logic [TIME_W-1:0]  o_Time_Left,
    output logic [2:0]         o_State
);

    game_state_t        state, state_next;
    logic               btn_q;
    logic [LIVES_W-1:0] lives, lives_next;
    logic [LEVEL_W-1:0] level, level_next;
    logic [SPEED_W-1:0] speed, speed_next;
    logic [SCORE_W-1:0] score, score_next;
    logic [TIME_W-1:0]  time_left, time_next;
    logic               game_active, game_active_next;
    logic               frog_reset, frog_reset_next;

    logic               start_edge;
    logic               state_change;
    logic               pause_en, pause_done, sec_done;
    logic [FRAME_W-1:0] pause_terminal;
    logic [SCORE_W:0]   cross_points;

    assign start_edge   = i_Start_Btn && !btn_q;
    assign state_change = (state_next != state);

`ifdef FROGG_TIME_BONUS_EN
    assign cross_points = (SCORE_W+1)'(P_CROSS_POINTS) + (SCORE_W+1)'(time_left);
`else
    assign cross_points = (SCORE_W+1)'(P_CROSS_POINTS);
`endif

    // Pick the pause length for whichever waiting state we are in
    always_comb begin
        pause_en       = 1'b1;
        pause_terminal = '0;
        case (state)
            READY:    pause_terminal = FRAME_W'(P_READY_FRAMES);
            DYING:    pause_terminal = FRAME_W'(P_DEATH_FRAMES);
            LEVEL_UP: pause_terminal = FRAME_W'(P_LEVELUP_FRAMES);
            default:  pause_en       = 1'b0;
        endcase
    end

    frogg_frame_timer #(.W(FRAME_W)) u_pause_timer (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .clear    (state_change),
        .enable   (pause_en),
        .tick     (i_Frame_Tick),
        .terminal (pause_terminal),
        .done     (pause_done)
    );

    frogg_frame_timer #(.W(FRAME_W)) u_sec_timer (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .clear    (state_change),
        .enable   (state == RUNNING),
        .tick     (i_Frame_Tick),
        .terminal (FRAME_W'(P_FRAMES_PER_SEC)),
        .done     (sec_done)
    );

    // Next-state and next-value logic for the whole round; collision and
    // goal inputs only matter while RUNNING
    always_comb begin
        state_next      = state;
        lives_next      = lives;
        level_next      = level;
        speed_next      = speed;
        score_next      = score;
        time_next       = time_left;
        frog_reset_next = 1'b0;
        case (state)
            IDLE, GAME_OVER: begin
                if (start_edge) begin
                    lives_next      = LIVES_W'(P_LIVES);
                    level_next      = LEVEL_W'(1);
                    speed_next      = SPEED_W'(1);
                    score_next      = '0;
                    frog_reset_next = 1'b1;
                    state_next      = READY;
                end
            end
            READY: begin
                if (pause_done)
                    state_next = RUNNING;
            end
            RUNNING: begin
                if (sec_done && time_left != '0)
                    time_next = time_left - TIME_W'(1);
                if (i_Collision || time_left == '0) begin
                    if (lives != '0)
                        lives_next = lives - LIVES_W'(1);
                    state_next = DYING;
                end else if (i_Reached_Top) begin
                    score_next = score_add(score, cross_points);
                    if (level < LEVEL_W'(LEVEL_MAX))
                        level_next = level + LEVEL_W'(1);
                    if (speed < SPEED_W'(P_MAX_SPEED))
                        speed_next = speed + SPEED_W'(1);
                    state_next = LEVEL_UP;
                end
            end
            DYING: begin
                if (pause_done) begin
                    if (lives == '0) begin
                        state_next = GAME_OVER;
                    end else begin
                        frog_reset_next = 1'b1;
                        state_next      = READY;
                    end
                end
            end
            LEVEL_UP: begin
                if (pause_done) begin
                    frog_reset_next = 1'b1;
                    state_next      = READY;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == READY && state != READY)
            time_next = TIME_W'(P_TIME_LIMIT);
        game_active_next = (state_next == RUNNING);
    end

    // Register state and every output so they all move one cycle after their cause
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= IDLE;
            btn_q       <= 1'b0;
            lives       <= LIVES_W'(P_LIVES);
            level       <= LEVEL_W'(1);
            speed       <= SPEED_W'(1);
            score       <= '0;
            time_left   <= TIME_W'(P_TIME_LIMIT);
            game_active <= 1'b0;
            frog_reset  <= 1'b0;
        end else begin
            state       <= state_next;
            btn_q       <= i_Start_Btn;
            lives       <= lives_next;
            level       <= level_next;
            speed       <= speed_next;
            score       <= score_next;
            time_left   <= time_next;
            game_active <= game_active_next;
            frog_reset  <= frog_reset_next;
        end
    end

    assign o_Game_Active = game_active;
    assign o_Frog_Reset  = frog_reset;
    assign o_Car_Speed   = speed;
    assign o_Lives       = lives;
    assign o_Level       = level;
    assign o_Score       = score;
    assign o_Time_Left   = time_left;
    assign o_State       = state;

endmodule

// File: tb/tb_frogg_round_ctrl.sv
// Directed bench for frogg_round_ctrl: full rounds, deaths, game over,
// timer expiry, level-up, mid-round reset and score/level/speed saturation.
module tb_frogg_round_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_Frame_Tick = 1'b0;
    logic       i_Start_Btn = 1'b0;
    logic       i_Collision = 1'b0;
    logic       i_Reached_Top = 1'b0;
    logic       o_Game_Active;
    logic       o_Frog_Reset;
    logic [3:0] o_Car_Speed;
    logic [1:0] o_Lives;
    logic [3:0] o_Level;
    logic [9:0] o_Score;
    logic [6:0] o_Time_Left;
    logic [2:0] o_State;

    int n_compared   = 0;
    int n_mismatched = 0;
    int pulse_cnt    = 0;
    int exp_score, exp_level, exp_speed;

    frogg_round_ctrl dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Frame_Tick  (i_Frame_Tick),
        .i_Start_Btn   (i_Start_Btn),
        .i_Collision   (i_Collision),
        .i_Reached_Top (i_Reached_Top),
        .o_Game_Active (o_Game_Active),
        .o_Frog_Reset  (o_Frog_Reset),
        .o_Car_Speed   (o_Car_Speed),
        .o_Lives       (o_Lives),
        .o_Level       (o_Level),
        .o_Score       (o_Score),
        .o_Time_Left   (o_Time_Left),
        .o_State       (o_State)
    );

    always #5 i_Clk = ~i_Clk;

    // Tally respawn pulses as the design presents them
    always @(posedge i_Clk) begin
        if (o_Frog_Reset)
            pulse_cnt <= pulse_cnt + 1;
    end

    function automatic int bonus(input int secs);
`ifdef FROGG_TIME_BONUS_EN
        return secs;
`else
        return 0 * secs;
`endif
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    // Drive n consecutive frame ticks, one per clock
    task automatic applyStimulus(input int n_ticks);
        i_Frame_Tick = 1'b1;
        repeat (n_ticks) @(negedge i_Clk);
        i_Frame_Tick = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        step(2);

        // Reset values
        checkOutput("rst_state", o_State, 0);
        checkOutput("rst_active", o_Game_Active, 0);
        checkOutput("rst_frog", o_Frog_Reset, 0);
        checkOutput("rst_speed", o_Car_Speed, 1);
        checkOutput("rst_lives", o_Lives, 3);
        checkOutput("rst_level", o_Level, 1);
        checkOutput("rst_score", o_Score, 0);
        checkOutput("rst_time", o_Time_Left, 30);
        i_Rst = 1'b0;
        step(1);

        // Plan 1: start edge, READY for 90 ticks, then RUNNING
        pulse_cnt   = 0;
        i_Start_Btn = 1'b1;
        step(1);
        checkOutput("start_state", o_State, 1);
        checkOutput("start_frog", o_Frog_Reset, 1);
        step(1);
        checkOutput("start_frog_once", o_Frog_Reset, 0);
        applyStimulus(89);
        checkOutput("ready_89", o_State, 1);
        applyStimulus(1);
        checkOutput("run_state", o_State, 2);
        checkOutput("run_active", o_Game_Active, 1);
        checkOutput("run_lives", o_Lives, 3);
        checkOutput("run_time", o_Time_Left, 30);
        checkOutput("start_pulses", pulse_cnt, 1);

        // Plan 2: collision beats reached-top in the same cycle
        i_Collision   = 1'b1;
        i_Reached_Top = 1'b1;
        step(1);
        i_Collision   = 1'b0;
        i_Reached_Top = 1'b0;
        checkOutput("prio_state", o_State, 3);
        checkOutput("prio_lives", o_Lives, 2);
        checkOutput("prio_score", o_Score, 0);
        checkOutput("prio_level", o_Level, 1);
        checkOutput("dying_active", o_Game_Active, 0);
        applyStimulus(59);
        checkOutput("dying_59", o_State, 3);
        applyStimulus(1);
        checkOutput("dying_ready", o_State, 1);
        checkOutput("dying_frog", o_Frog_Reset, 1);
        step(1);
        checkOutput("dying_frog_once", o_Frog_Reset, 0);

        // Collisions are ignored while READY
        i_Collision = 1'b1;
        step(5);
        i_Collision = 1'b0;
        checkOutput("gate_state", o_State, 1);
        checkOutput("gate_lives", o_Lives, 2);

        // Plan 3: two more deaths lead to GAME_OVER
        for (int k = 0; k < 2; k++) begin
            applyStimulus(90);
            checkOutput("loop_run", o_State, 2);
            i_Collision = 1'b1;
            step(1);
            i_Collision = 1'b0;
            checkOutput("loop_lives", o_Lives, 1 - k);
            applyStimulus(60);
        end
        checkOutput("over_state", o_State, 5);
        checkOutput("over_lives", o_Lives, 0);
        checkOutput("over_frog", o_Frog_Reset, 0);
        step(5);
        checkOutput("over_held_btn", o_State, 5);
        i_Start_Btn = 1'b0;
        step(2);
        i_Start_Btn = 1'b1;
        step(1);
        checkOutput("restart_state", o_State, 1);
        checkOutput("restart_lives", o_Lives, 3);
        checkOutput("restart_score", o_Score, 0);
        checkOutput("restart_frog", o_Frog_Reset, 1);
        i_Start_Btn = 1'b0;

        // Plan 4: timer expiry
        applyStimulus(90);
        checkOutput("t_run", o_State, 2);
        applyStimulus(60);
        checkOutput("t_29", o_Time_Left, 29);
        applyStimulus(1680);
        checkOutput("t_1", o_Time_Left, 1);
        applyStimulus(59);
        checkOutput("t_1_still", o_Time_Left, 1);
        applyStimulus(1);
        checkOutput("t_0", o_Time_Left, 0);
        checkOutput("t_0_state", o_State, 2);
        step(1);
        checkOutput("t_dying", o_State, 3);
        checkOutput("t_lives", o_Lives, 2);
        applyStimulus(60);
        checkOutput("t_ready", o_State, 1);
        checkOutput("t_reload", o_Time_Left, 30);

        // Plan 5: reach the top with 17 s left
        applyStimulus(90);
        applyStimulus(780);
        checkOutput("lu_time", o_Time_Left, 17);
        i_Reached_Top = 1'b1;
        step(1);
        i_Reached_Top = 1'b0;
        checkOutput("lu_state", o_State, 4);
        checkOutput("lu_level", o_Level, 2);
        checkOutput("lu_speed", o_Car_Speed, 2);
        checkOutput("lu_score", o_Score, 10 + bonus(17));
        checkOutput("lu_lives", o_Lives, 2);
        applyStimulus(59);
        checkOutput("lu_59", o_State, 4);
        applyStimulus(1);
        checkOutput("lu_ready", o_State, 1);
        checkOutput("lu_frog", o_Frog_Reset, 1);

        // Plan 6: reset in the middle of LEVEL_UP
        applyStimulus(90);
        i_Reached_Top = 1'b1;
        step(1);
        i_Reached_Top = 1'b0;
        checkOutput("lu2_state", o_State, 4);
        applyStimulus(10);
        pulse_cnt = 0;
        i_Rst     = 1'b1;
        step(1);
        checkOutput("mrst_state", o_State, 0);
        checkOutput("mrst_score", o_Score, 0);
        checkOutput("mrst_level", o_Level, 1);
        checkOutput("mrst_speed", o_Car_Speed, 1);
        checkOutput("mrst_lives", o_Lives, 3);
        checkOutput("mrst_frog", o_Frog_Reset, 0);
        i_Rst = 1'b0;
        step(3);
        checkOutput("mrst_idle", o_State, 0);
        checkOutput("mrst_pulses", pulse_cnt, 0);

        // Saturation of score, level and speed over 100 quick crossings
        i_Start_Btn = 1'b1;
        step(1);
        i_Start_Btn = 1'b0;
        exp_score = 0;
        exp_level = 1;
        exp_speed = 1;
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(90);
            i_Reached_Top = 1'b1;
            step(1);
            i_Reached_Top = 1'b0;
            exp_score = exp_score + 10 + bonus(30);
            if (exp_score > 999) exp_score = 999;
            if (exp_level < 15) exp_level++;
            if (exp_speed < 15) exp_speed++;
            if (k == 99)  checkOutput("sat_score_99", o_Score, exp_score);
            if (k == 100) checkOutput("sat_score_100", o_Score, exp_score);
            applyStimulus(60);
        end
        checkOutput("sat_score_max", o_Score, 999);
        checkOutput("sat_level", o_Level, exp_level);
        checkOutput("sat_level_max", o_Level, 15);
        checkOutput("sat_speed", o_Car_Speed, exp_speed);
        checkOutput("sat_lives", o_Lives, 3);
        checkOutput("sat_state", o_State, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
